// File: rtl/hazard_pkg.sv
// Shared types for the EXE hazard controller.
// FSM states, forwarding selects, MDU counter width.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    MDU_BUSY     = 2'd1,
    EXC_REDIRECT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int CNT_W = 4;

  // Nearest producer wins; $0 never forwards.
  function automatic logic [1:0] fwd_pick(
    input logic       mw,
    input logic [4:0] md,
    input logic       ww,
    input logic [4:0] wd,
    input logic [4:0] src
  );
    if (mw && md != 5'd0 && md == src)
      return FWD_MEM;
    if (ww && wd != 5'd0 && wd == src)
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mdu_stall_counter.sv
// Down-counter timing the remaining MDU hold cycles.
// Ports: CLK, RST_N, load, dec -> count, zero.
module mdu_stall_counter
  import hazard_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOAD_VAL = 4'd2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      count <= '0;
    else if (load)
      count <= LOAD_VAL;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Stall/bubble/flush/forward control around ID/EXE.
// Ports: hazard fields in, pipeline enables/flushes/fwd out. Macro: HAZARD_FWD_EN.
module exe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         MDU_LATENCY = 4,
  parameter logic [7:0] EXC_VECTOR  = 8'h80
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_dst,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic       ex_mdu,
  input  logic       ex_exception,
  input  logic [7:0] ex_pc,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  input  logic [4:0] mem_dst,
  input  logic [4:0] wb_dst,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       id_exe_bubble,
  output logic       exe_hold,
  output logic       flush_if_id,
  output logic       flush_id_exe,
  output logic       flush_exe_mem,
  output logic       pc_sel_exc,
  output logic [7:0] epc,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam logic [CNT_W-1:0] MDU_LOAD =
    CNT_W'(MDU_LATENCY - 2);

  generate
    if (MDU_LATENCY < 2 || MDU_LATENCY > 15)
      $error("MDU_LATENCY out of range");
    if (EXC_VECTOR[1:0] != 2'b00)
      $error("EXC_VECTOR must be word aligned");
  endgenerate

  state_e           st;
  state_e           st_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             data_haz;
  logic             run_exc;
  logic             run_mdu;
  logic             run_haz;

  function automatic logic id_reads(input logic [4:0] r);
    return (r == id_rs) || (id_uses_rt && r == id_rt);
  endfunction

`ifdef HAZARD_FWD_EN
  assign data_haz = ex_mem_read && ex_dst != 5'd0
                 && id_reads(ex_dst);
  assign fwd_a = fwd_pick(mem_reg_write, mem_dst,
                          wb_reg_write, wb_dst, ex_rs);
  assign fwd_b = fwd_pick(mem_reg_write, mem_dst,
                          wb_reg_write, wb_dst, ex_rt);
`else
  // No bypass: stall until the producer reaches WB,
  // where the register file write precedes the read.
  assign data_haz =
      (ex_reg_write && ex_dst != 5'd0 && id_reads(ex_dst))
   || (mem_reg_write && mem_dst != 5'd0 && id_reads(mem_dst));
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  logic unused_ok;
  assign unused_ok = ^{ex_rs, ex_rt, ex_reg_write,
                       ex_mem_read, wb_reg_write, wb_dst,
                       mem_reg_write, mem_dst, cnt};

  assign run_exc = (st == RUN) && ex_exception;
  assign run_mdu = (st == RUN) && !ex_exception && ex_mdu;
  assign run_haz = (st == RUN) && !ex_exception && !ex_mdu
                && data_haz;

  mdu_stall_counter #(
    .LOAD_VAL (MDU_LOAD)
  ) u_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (run_mdu),
    .dec   (st == MDU_BUSY),
    .count (cnt),
    .zero  (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      st <= RUN;
    else
      st <= st_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      epc <= 8'h00;
    else if (run_exc)
      epc <= ex_pc;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      RUN: begin
        if (ex_exception)
          st_nx = EXC_REDIRECT;
        else if (ex_mdu)
          st_nx = MDU_BUSY;
      end
      MDU_BUSY: begin
        if (cnt_zero)
          st_nx = RUN;
      end
      EXC_REDIRECT: st_nx = RUN;
      default:      st_nx = RUN;
    endcase
  end

  // Outputs are forced to idle while reset is held so
  // the pipeline sees a clean state immediately.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_exe_bubble  = 1'b0;
    exe_hold       = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_exe   = 1'b0;
    flush_exe_mem  = 1'b0;
    pc_sel_exc     = 1'b0;
    if (RST_N) begin
      unique case (1'b1)
        (st == EXC_REDIRECT): begin
          pc_sel_exc   = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_exe = 1'b1;
        end
        (st == MDU_BUSY), run_mdu: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          exe_hold       = 1'b1;
          flush_exe_mem  = 1'b1;
        end
        run_exc: begin
          pc_write_en   = 1'b0;
          flush_if_id   = 1'b1;
          flush_id_exe  = 1'b1;
          flush_exe_mem = 1'b1;
        end
        run_haz: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_exe_bubble  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
